// File: rtl/term_writer.sv
// Byte-stream writer for the 60x17 text VRAM: decodes printable and control bytes
// and drives VRAM port A to place glyphs, blank rows and clear the screen.
module term_writer #(
    parameter int unsigned COLS  = 60,
    parameter int unsigned ROWS  = 17,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_data,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [10:0] o_vram_addr,
    output logic [7:0]  o_vram_din,
    output logic        o_vram_ce,
    output logic        o_vram_wre,
    output logic        o_cursor_e
);

    localparam int unsigned ROW_W = 5;
    localparam int unsigned COL_W = 6;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_DEL = 8'h7F;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        CLEAR_ROW,
        CLEAR_ALL
    } state_t;

    state_t           state;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] crow;
    logic [COL_W-1:0] ccol;
    logic             row_step;

    logic [ROW_W-1:0] step_row;
    logic             printable;

    // Row step wraps to the top; there is no scrolling.
    assign step_row  = (row == LAST_ROW) ? ROW_W'(0) : row + ROW_W'(1);
    assign printable = (i_data >= 8'h20) && (i_data != CH_DEL);

    // The block never reads VRAM, and the cursor is shown whenever input is accepted.
    assign o_vram_wre = o_vram_ce;
    assign o_cursor_e = o_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= CLEAR_ALL;
            row         <= '0;
            col         <= '0;
            crow        <= '0;
            ccol        <= '0;
            row_step    <= 1'b0;
            o_ready     <= 1'b0;
            o_vram_ce   <= 1'b0;
            o_vram_addr <= '0;
            o_vram_din  <= '0;
        end else begin
            o_vram_ce <= 1'b0;
            case (state)
                IDLE: begin
                    if (o_ready && i_valid) begin
                        if (printable) begin
                            o_ready     <= 1'b0;
                            o_vram_ce   <= 1'b1;
                            o_vram_addr <= {row, col};
                            o_vram_din  <= i_data;
                            state       <= WRITE;
                            if (col == LAST_COL) begin
                                col      <= '0;
                                row      <= step_row;
                                row_step <= 1'b1;
                            end else begin
                                col      <= col + COL_W'(1);
                                row_step <= 1'b0;
                            end
                        end else begin
                            case (i_data)
                                CH_CR: begin
                                    col         <= '0;
                                    o_vram_addr <= {row, COL_W'(0)};
                                end
                                CH_LF: begin
                                    // First blank of the destination row goes out on the accept edge.
                                    col         <= '0;
                                    row         <= step_row;
                                    ccol        <= COL_W'(1);
                                    o_ready     <= 1'b0;
                                    o_vram_ce   <= 1'b1;
                                    o_vram_addr <= {step_row, COL_W'(0)};
                                    o_vram_din  <= BLANK;
                                    state       <= CLEAR_ROW;
                                end
                                CH_BS: begin
                                    if (col != '0) begin
                                        col         <= col - COL_W'(1);
                                        row_step    <= 1'b0;
                                        o_ready     <= 1'b0;
                                        o_vram_ce   <= 1'b1;
                                        o_vram_addr <= {row, col - COL_W'(1)};
                                        o_vram_din  <= BLANK;
                                        state       <= WRITE;
                                    end
                                end
                                CH_FF: begin
                                    row         <= '0;
                                    col         <= '0;
                                    crow        <= '0;
                                    ccol        <= COL_W'(1);
                                    o_ready     <= 1'b0;
                                    o_vram_ce   <= 1'b1;
                                    o_vram_addr <= '0;
                                    o_vram_din  <= BLANK;
                                    state       <= CLEAR_ALL;
                                end
                                default: ;
                            endcase
                        end
                    end else begin
                        o_ready     <= 1'b1;
                        o_vram_addr <= {row, col};
                    end
                end

                WRITE: begin
                    if (row_step) begin
                        ccol        <= COL_W'(1);
                        o_vram_ce   <= 1'b1;
                        o_vram_addr <= {row, COL_W'(0)};
                        o_vram_din  <= BLANK;
                        state       <= CLEAR_ROW;
                    end else begin
                        o_ready     <= 1'b1;
                        o_vram_addr <= {row, col};
                        state       <= IDLE;
                    end
                end

                CLEAR_ROW: begin
                    o_vram_ce   <= 1'b1;
                    o_vram_addr <= {row, ccol};
                    o_vram_din  <= BLANK;
                    if (ccol == LAST_COL) begin
                        state <= IDLE;
                    end else begin
                        ccol <= ccol + COL_W'(1);
                    end
                end

                CLEAR_ALL: begin
                    o_vram_ce   <= 1'b1;
                    o_vram_addr <= {crow, ccol};
                    o_vram_din  <= BLANK;
                    if (ccol == LAST_COL) begin
                        ccol <= '0;
                        if (crow == LAST_ROW) begin
                            crow  <= '0;
                            row   <= '0;
                            col   <= '0;
                            state <= IDLE;
                        end else begin
                            crow <= crow + ROW_W'(1);
                        end
                    end else begin
                        ccol <= ccol + COL_W'(1);
                    end
                end

                default: state <= CLEAR_ALL;
            endcase
        end
    end

endmodule
